// File: rtl/saturn_def_buscmd.sv
// Shared definitions for the Saturn bus-program queue: BUSCMD codes,
// program-entry layout and the serialiser FSM state encoding.
package saturn_def_buscmd;

  localparam int ENTRY_W        = 5;
  localparam int ENTRY_FLAG_BIT = 4;

  typedef enum logic [3:0] {
    BUSCMD_PC_READ     = 4'h0,
    BUSCMD_DP_WRITE    = 4'h1,
    BUSCMD_DP_READ     = 4'h2,
    BUSCMD_PC_WRITE    = 4'h3,
    BUSCMD_LOAD_PC     = 4'h4,
    BUSCMD_LOAD_DP     = 4'h5,
    BUSCMD_CONFIGURE   = 4'h6,
    BUSCMD_UNCONFIGURE = 4'h7,
    BUSCMD_ID          = 4'h8,
    BUSCMD_PC_READ_ALT = 4'h9,
    BUSCMD_RESET       = 4'hF
  } buscmd_e;

  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_SERIAL = 1'b1
  } busq_state_e;

  // Flag bit set marks a command entry, clear marks an address nibble.
  function automatic logic [ENTRY_W-1:0] make_entry(input logic is_cmd,
                                                    input logic [3:0] payload);
    return {is_cmd, payload};
  endfunction

endpackage

// File: rtl/saturn_busq_fifo.sv
// Circular entry store for the bus-program queue: pointers, occupancy count,
// full/empty and sticky underflow. Macro SATURN_BUSQ_HIGH_WATER_EN adds a high-water register.
module saturn_busq_fifo
  import saturn_def_buscmd::*;
#(
  parameter int DEPTH = 32,
  parameter int PTR_W = $clog2(DEPTH)
) (
  input  logic               i_clk,
  input  logic               i_reset_n,
  input  logic               i_clk_en,
  input  logic               i_flush,
  input  logic               i_wr_en,
  input  logic [ENTRY_W-1:0] i_wr_data,
  input  logic               i_rd_en,
  output logic [ENTRY_W-1:0] o_rd_data,
  output logic               o_empty,
  output logic               o_full,
  output logic [PTR_W:0]     o_count,
  output logic               o_underflow,
  output logic [PTR_W:0]     o_high_water
);

  logic [ENTRY_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0]   wr_ptr, rd_ptr;
  logic [PTR_W:0]     count, count_nxt;
  logic               underflow;
  logic               push, pop, pop_empty;

  assign push      = i_clk_en & i_wr_en;
  assign pop       = i_clk_en & i_rd_en & (count != '0);
  assign pop_empty = i_clk_en & i_rd_en & (count == '0);

  always_comb begin
    count_nxt = count;
    if (i_flush)
      count_nxt = '0;
    else if (push && !pop)
      count_nxt = count + 1'b1;
    else if (pop && !push)
      count_nxt = count - 1'b1;
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      underflow <= 1'b0;
    end else if (i_clk_en) begin
      count <= count_nxt;
      if (i_flush) begin
        wr_ptr    <= '0;
        rd_ptr    <= '0;
        underflow <= 1'b0;
      end else begin
        if (push)      wr_ptr    <= wr_ptr + 1'b1;
        if (pop)       rd_ptr    <= rd_ptr + 1'b1;
        if (pop_empty) underflow <= 1'b1;
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (push && !i_flush)
      mem[wr_ptr] <= i_wr_data;
  end

  assign o_rd_data   = mem[rd_ptr];
  assign o_empty     = (count == '0);
  assign o_full      = (count == (PTR_W+1)'(DEPTH));
  assign o_count     = count;
  assign o_underflow = underflow;

`ifdef SATURN_BUSQ_HIGH_WATER_EN
  logic [PTR_W:0] high_water;

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n)
      high_water <= '0;
    else if (i_clk_en) begin
      if (i_flush)
        high_water <= '0;
      else if (count_nxt > high_water)
        high_water <= count_nxt;
    end
  end

  assign o_high_water = high_water;
`else
  assign o_high_water = '0;
`endif

endmodule

// File: rtl/saturn_bus_program_queue.sv
// Bus-program builder: turns command/address requests into 5-bit program
// entries queued in a FIFO. Optional macro: SATURN_BUSQ_HIGH_WATER_EN.
//
//   state     | meaning
//   ----------+-------------------------------------------------------
//   ST_IDLE   | accepting requests when enough space is free
//   ST_SERIAL | writing latched address nibbles, LS nibble first
module saturn_bus_program_queue
  import saturn_def_buscmd::*;
#(
  parameter int DEPTH        = 32,
  parameter int ADDR_NIBBLES = 5,
  parameter int PTR_W        = $clog2(DEPTH)
) (
  input  logic                      i_clk,
  input  logic                      i_reset_n,
  input  logic                      i_clk_en,
  input  logic                      i_flush,
  input  logic                      i_req_valid,
  output logic                      o_req_ready,
  input  logic [3:0]                i_req_cmd,
  input  logic                      i_req_has_addr,
  input  logic [4*ADDR_NIBBLES-1:0] i_req_addr,
  input  logic                      i_rd_en,
  output logic [ENTRY_W-1:0]        o_rd_data,
  output logic                      o_empty,
  output logic                      o_full,
  output logic [PTR_W:0]            o_count,
  output logic                      o_busy,
  output logic                      o_underflow,
  output logic [PTR_W:0]            o_high_water
);

  localparam int NIB_W  = (ADDR_NIBBLES > 1) ? $clog2(ADDR_NIBBLES) : 1;
  localparam int ADDR_W = 4 * ADDR_NIBBLES;

  busq_state_e        state_q, state_d;
  logic [NIB_W-1:0]   nibble_q, nibble_d;
  logic [ADDR_W-1:0]  addr_q, addr_d;
  logic [PTR_W:0]     count, free, need;
  logic               room, accept;
  logic               wr_en;
  logic [ENTRY_W-1:0] wr_data;

  // Space check uses start-of-cycle count; a same-cycle pop is not credited.
  assign free   = (PTR_W+1)'(DEPTH) - count;
  assign need   = i_req_has_addr ? (PTR_W+1)'(ADDR_NIBBLES + 1) : (PTR_W+1)'(1);
  assign room   = (state_q == ST_IDLE) && (free >= need);
  assign o_req_ready = room & i_reset_n & ~(i_flush & i_clk_en);
  assign accept = i_req_valid & o_req_ready & i_clk_en;
  assign o_busy = (state_q == ST_SERIAL);

  always_comb begin
    state_d  = state_q;
    nibble_d = nibble_q;
    addr_d   = addr_q;
    wr_en    = 1'b0;
    wr_data  = '0;
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          wr_en   = 1'b1;
          wr_data = make_entry(1'b1, i_req_cmd);
          if (i_req_has_addr) begin
            addr_d   = i_req_addr;
            nibble_d = '0;
            state_d  = ST_SERIAL;
          end
        end
      end
      ST_SERIAL: begin
        wr_en    = i_clk_en;
        wr_data  = make_entry(1'b0, addr_q[3:0]);
        addr_d   = addr_q >> 4;
        nibble_d = nibble_q + 1'b1;
        if (nibble_q == NIB_W'(ADDR_NIBBLES - 1)) begin
          nibble_d = '0;
          state_d  = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    if (i_flush) begin
      state_d  = ST_IDLE;
      nibble_d = '0;
    end
  end

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state_q  <= ST_IDLE;
      nibble_q <= '0;
      addr_q   <= '0;
    end else if (i_clk_en) begin
      state_q  <= state_d;
      nibble_q <= nibble_d;
      addr_q   <= addr_d;
    end
  end

  saturn_busq_fifo #(
    .DEPTH (DEPTH),
    .PTR_W (PTR_W)
  ) u_fifo (
    .i_clk        (i_clk),
    .i_reset_n    (i_reset_n),
    .i_clk_en     (i_clk_en),
    .i_flush      (i_flush),
    .i_wr_en      (wr_en),
    .i_wr_data    (wr_data),
    .i_rd_en      (i_rd_en),
    .o_rd_data    (o_rd_data),
    .o_empty      (o_empty),
    .o_full       (o_full),
    .o_count      (count),
    .o_underflow  (o_underflow),
    .o_high_water (o_high_water)
  );

  assign o_count = count;

endmodule

// File: tb/tb_saturn_bus_program_queue.sv
// Randomised bench for saturn_bus_program_queue against a queue-based model
// of the program stream (entries plus pending address nibbles).
module tb_saturn_bus_program_queue;
  import saturn_def_buscmd::*;

  localparam int DEPTH = 32;
  localparam int AN    = 5;
  localparam int PW    = 5;

  logic          clk = 1'b0;
  logic          reset_n, clk_en, flush, req_valid, req_has_addr, rd_en;
  logic [3:0]    req_cmd;
  logic [4*AN-1:0] req_addr;
  logic          req_ready, empty, full, busy, underflow;
  logic [4:0]    rd_data;
  logic [PW:0]   count, high_water;

  always #5 clk = ~clk;

  saturn_bus_program_queue #(.DEPTH(DEPTH), .ADDR_NIBBLES(AN)) dut (
    .i_clk          (clk),
    .i_reset_n      (reset_n),
    .i_clk_en       (clk_en),
    .i_flush        (flush),
    .i_req_valid    (req_valid),
    .o_req_ready    (req_ready),
    .i_req_cmd      (req_cmd),
    .i_req_has_addr (req_has_addr),
    .i_req_addr     (req_addr),
    .i_rd_en        (rd_en),
    .o_rd_data      (rd_data),
    .o_empty        (empty),
    .o_full         (full),
    .o_count        (count),
    .o_busy         (busy),
    .o_underflow    (underflow),
    .o_high_water   (high_water)
  );

  bit [4:0] mq[$];
  bit [4:0] pend[$];
  bit       m_und;
  int       m_hw;
  int       n_tests = 0;
  int       n_fail  = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic bit exp_ready();
    int need;
    need = req_has_addr ? AN + 1 : 1;
    return reset_n && (pend.size() == 0) && ((DEPTH - mq.size()) >= need)
           && !(flush && clk_en);
  endfunction

  task automatic model_clear();
    mq.delete();
    pend.delete();
    m_und = 0;
    m_hw  = 0;
  endtask

  // Called at a negedge with inputs already driven; checks, then advances one cycle.
  task automatic step();
    bit acc;
    #1;
    chk("ready", req_ready, exp_ready());
    chk("count", count, mq.size());
    chk("empty", empty, mq.size() == 0);
    chk("full", full, mq.size() == DEPTH);
    chk("busy", busy, pend.size() != 0);
    chk("underflow", underflow, m_und);
    if (mq.size() != 0) chk("rd_data", rd_data, mq[0]);
`ifdef SATURN_BUSQ_HIGH_WATER_EN
    chk("high_water", high_water, m_hw);
`else
    chk("high_water_tied", high_water, 0);
`endif
    acc = exp_ready() && req_valid && clk_en;
    if (!reset_n) model_clear();
    else if (clk_en) begin
      if (flush) model_clear();
      else begin
        if (rd_en) begin
          if (mq.size() == 0) m_und = 1;
          else void'(mq.pop_front());
        end
        if (pend.size() != 0) mq.push_back(pend.pop_front());
        if (acc) begin
          mq.push_back({1'b1, req_cmd});
          if (req_has_addr)
            for (int i = 0; i < AN; i++) pend.push_back({1'b0, req_addr[4*i +: 4]});
        end
        if (mq.size() > m_hw) m_hw = mq.size();
      end
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic idle_inputs();
    clk_en = 1; flush = 0; req_valid = 0; req_has_addr = 0; rd_en = 0;
    req_cmd = '0; req_addr = '0;
  endtask

  bit [4:0] exp_seq [6];

  initial begin
    exp_seq[0] = {1'b1, BUSCMD_LOAD_PC};
    exp_seq[1] = 5'h05; exp_seq[2] = 5'h04; exp_seq[3] = 5'h03;
    exp_seq[4] = 5'h02; exp_seq[5] = 5'h01;
    model_clear();
    idle_inputs();
    reset_n   = 0;
    req_valid = 1;
    @(negedge clk);
    step();
    step();
    reset_n = 1;
    req_valid = 0;
    step();

    // Addressed LOAD_PC request and its serialised program
    req_valid = 1; req_cmd = BUSCMD_LOAD_PC; req_has_addr = 1; req_addr = 20'h12345;
    step();
    req_valid = 0;
    for (int k = 0; k < 5; k++) begin
      #1 chk("busy_serial", busy, 1);
      step();
    end
    #1 chk("count_after_load_pc", count, 6);
    rd_en = 1;
    for (int k = 0; k < 6; k++) begin
      #1 chk("prog_seq", rd_data, exp_seq[k]);
      step();
    end
    rd_en = 0;

    // Fill to 28, then an addressed request needs 6 slots
    req_valid = 1; req_has_addr = 0;
    for (int k = 0; k < 60 && mq.size() < 28; k++) begin
      req_cmd = 4'($urandom);
      step();
    end
    req_has_addr = 1; req_addr = 20'($urandom);
    #1 chk("ready_blocked_at_28", req_ready, 0);
    step();
    rd_en = 1;
    step();
    step();
    rd_en = 0;
    #1 chk("ready_after_pop2", req_ready, 1);
    step();
    req_valid = 0;
    repeat (5) step();
    #1 chk("full_after_serial", full, 1);
    step();

    // Continuous push/pop through wrap-around
    flush = 1; step(); flush = 0;
    req_valid = 1; req_has_addr = 0; rd_en = 1;
    for (int k = 0; k < 50; k++) begin
      req_cmd = 4'($urandom);
      step();
    end
    req_valid = 0;
    step();

    // Randomised traffic
    for (int k = 0; k < 600; k++) begin
      clk_en       = ($urandom_range(9) != 0);
      flush        = ($urandom_range(60) == 0);
      req_valid    = $urandom_range(1);
      req_cmd      = 4'($urandom);
      req_has_addr = $urandom_range(1);
      req_addr     = 20'($urandom);
      rd_en        = ($urandom_range(2) != 0);
      step();
    end
    idle_inputs();

    // Drain, pop while empty, sticky until flush
    rd_en = 1;
    for (int k = 0; k < 40 && (mq.size() != 0 || pend.size() != 0); k++) step();
    step();
    rd_en = 0;
    #1 chk("underflow_set", underflow, 1);
    step();
    step();
    flush = 1; step(); flush = 0;
    step();

    // Flush mid-serialisation at nibble 2
    req_valid = 1; req_has_addr = 1; req_cmd = BUSCMD_LOAD_DP; req_addr = 20'($urandom);
    step();
    req_valid = 0;
    step();
    step();
    flush = 1; step(); flush = 0;
    #1 chk("count_after_flush", count, 0);
    step();
    req_valid = 1; req_has_addr = 0; req_cmd = BUSCMD_DP_READ;
    step();
    req_valid = 0;
    step();

    // Async reset mid-stream
    rd_en = 1; step(); step(); step(); rd_en = 0;
    req_valid = 1; req_has_addr = 1; req_addr = 20'($urandom);
    step();
    step();
    #2 reset_n = 0;
    #1;
    chk("rst_count", count, 0);
    chk("rst_empty", empty, 1);
    chk("rst_full", full, 0);
    chk("rst_busy", busy, 0);
    chk("rst_underflow", underflow, 0);
    chk("rst_ready", req_ready, 0);
    chk("rst_high_water", high_water, 0);
    model_clear();
    @(negedge clk);
    step();
    reset_n = 1;
    req_valid = 0;
    step();
    step();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
